// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline control types: the per-cycle control bundle, D-cache miss
// FSM states and default hazard-unit constants.
package pipeline_hazard_ctrl_pkg;

  typedef struct packed {
    logic takebranch;
    logic stall;
    logic dcache_stall;
    logic load_use_stall;
  } control_signals_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_MISS = 1'b1
  } dstate_e;

  localparam int MUL_LATENCY_DEFAULT  = 4;
  localparam int MISS_TIMEOUT_DEFAULT = 256;
  localparam int PERF_W_DEFAULT       = 32;

  function automatic logic src_matches(input logic uses, input logic [4:0] src,
                                       input logic [4:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_miss_fsm.sv
// D-cache miss sequencer: tracks an outstanding refill, raises the stall for
// its duration and flags a refill that never completes.
module hazard_miss_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic hit_i,
  input  logic fill_done_i,
  output logic dcache_stall_o,
  output logic timeout_err_o
);

  localparam int          TW     = $clog2(MISS_TIMEOUT + 1);
  localparam logic [31:0] ERR_AT = 32'(MISS_TIMEOUT - 1);

  dstate_e         state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            miss_start;

  always_comb begin
    miss_start = (state_q == D_IDLE) && req_i && !hit_i;
    state_d    = state_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    case (state_q)
      D_IDLE: begin
        if (miss_start) begin
          state_d = D_MISS;
          tmo_d   = '0;
        end
      end
      D_MISS: begin
        if (fill_done_i) state_d = D_IDLE;
        if (tmo_q != {TW{1'b1}}) tmo_d = tmo_q + TW'(1);
        // tmo_q counts completed D_MISS cycles; the flag lands once the
        // current cycle brings the total to MISS_TIMEOUT-1.
        if (32'(tmo_q) + 32'd1 >= ERR_AT) err_d = 1'b1;
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= D_IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign dcache_stall_o = miss_start || ((state_q == D_MISS) && !fill_done_i);
  assign timeout_err_o  = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: combines D-cache miss, multi-cycle multiply and
// load-use hazards into the stall/branch control bundle for the register bank.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY  = MUL_LATENCY_DEFAULT,
  parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEFAULT,
  parameter int PERF_W       = PERF_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic              ex_branch_taken,
  input  logic              ex_mul_start,
  input  logic              mem_dc_req,
  input  logic              mem_dc_hit,
  input  logic              dc_fill_done,
  output control_signals_t  ctrl_signals,
  output logic              miss_timeout_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int             CW           = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
  localparam logic           START_STALLS = 1'(MUL_LATENCY > 1);
  localparam logic [CW-1:0]  MUL_RELOAD   = (MUL_LATENCY > 2) ? CW'(MUL_LATENCY - 2) : '0;

  logic              dcache_stall;
  logic              mul_busy, mul_load, mul_stall;
  logic              hazard, load_use_stall, stall, takebranch;
  logic [CW-1:0]     mul_cnt_q, mul_cnt_d;
  logic              pend_q, pend_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  hazard_miss_fsm #(
    .MISS_TIMEOUT (MISS_TIMEOUT)
  ) u_miss_fsm (
    .clk_i          (clock),
    .rst_ni         (reset),
    .req_i          (mem_dc_req),
    .hit_i          (mem_dc_hit),
    .fill_done_i    (dc_fill_done),
    .dcache_stall_o (dcache_stall),
    .timeout_err_o  (miss_timeout_err)
  );

  always_comb begin
    // mul_cnt holds the stall cycles still owed after the start cycle, so the
    // start cycle plus the countdown hold EX for MUL_LATENCY-1 extra cycles.
    mul_busy       = (mul_cnt_q != '0);
    mul_load       = ex_mul_start && !mul_busy && !dcache_stall && START_STALLS;
    mul_stall      = mul_busy || mul_load;
    hazard         = ex_is_load && (ex_rd != 5'd0) &&
                     (src_matches(id_uses_rs1, id_rs1, ex_rd) ||
                      src_matches(id_uses_rs2, id_rs2, ex_rd));
    load_use_stall = hazard && !dcache_stall && !mul_stall;
    stall          = dcache_stall || mul_stall || load_use_stall;
    takebranch     = (ex_branch_taken || pend_q) && !stall;

    mul_cnt_d = mul_cnt_q;
    if (mul_load) mul_cnt_d = MUL_RELOAD;
    else if (mul_busy && !dcache_stall) mul_cnt_d = mul_cnt_q - CW'(1);

    pend_d = pend_q;
    if (takebranch) pend_d = 1'b0;
    else if (ex_branch_taken && stall) pend_d = 1'b1;

    perf_d = perf_q;
    if (stall && (perf_q != {PERF_W{1'b1}})) perf_d = perf_q + PERF_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mul_cnt_q <= '0;
      pend_q    <= 1'b0;
      perf_q    <= '0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
      pend_q    <= pend_d;
      perf_q    <= perf_d;
    end
  end

  // Outputs are held quiet while reset is asserted, independent of inputs.
  always_comb begin
    ctrl_signals = '0;
    if (reset) begin
      ctrl_signals.takebranch     = takebranch;
      ctrl_signals.stall          = stall;
      ctrl_signals.dcache_stall   = dcache_stall;
      ctrl_signals.load_use_stall = load_use_stall;
    end
  end

  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised and directed scoreboard bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int L  = 4;
  localparam int TO = 256;
  localparam int PW = 32;

  logic             clock;
  logic             reset;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, ex_is_load;
  logic             ex_branch_taken, ex_mul_start;
  logic             mem_dc_req, mem_dc_hit, dc_fill_done;
  control_signals_t ctrl_signals;
  logic             miss_timeout_err;
  logic [PW-1:0]    stall_cycles;

  pipeline_hazard_ctrl #(
    .MUL_LATENCY  (L),
    .MISS_TIMEOUT (TO),
    .PERF_W       (PW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_is_load       (ex_is_load),
    .ex_rd            (ex_rd),
    .ex_branch_taken  (ex_branch_taken),
    .ex_mul_start     (ex_mul_start),
    .mem_dc_req       (mem_dc_req),
    .mem_dc_hit       (mem_dc_hit),
    .dc_fill_done     (dc_fill_done),
    .ctrl_signals     (ctrl_signals),
    .miss_timeout_err (miss_timeout_err),
    .stall_cycles     (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit       rst_n;
    bit [4:0] rs1, rs2, rd;
    bit       u1, u2, ld, br, ms, req, hit, fill;
  } stim_t;

  typedef struct {
    control_signals_t ctrl;
    bit               err;
    logic [PW-1:0]    perf;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Behavioural model state
  bit      m_miss;
  int      m_miss_cycles;
  bit      m_err;
  int      m_mul_left;
  bit      m_pend;
  longint  m_perf;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, u1: 1'b0, u2: 1'b0,
          ld: 1'b0, br: 1'b0, ms: 1'b0, req: 1'b0, hit: 1'b0, fill: 1'b0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst_n = ($urandom_range(0, 199) != 0);
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.rd    = 5'($urandom_range(0, 3));
    s.u1    = ($urandom_range(0, 1) == 1);
    s.u2    = ($urandom_range(0, 1) == 1);
    s.ld    = ($urandom_range(0, 99) < 40);
    s.br    = ($urandom_range(0, 99) < 20);
    s.ms    = ($urandom_range(0, 99) < 10);
    s.req   = ($urandom_range(0, 99) < 30);
    s.hit   = ($urandom_range(0, 99) < 50);
    s.fill  = ($urandom_range(0, 99) < 20);
    return s;
  endfunction

  task automatic model_reset();
    m_miss = 0; m_miss_cycles = 0; m_err = 0;
    m_mul_left = 0; m_pend = 0; m_perf = 0;
  endtask

  task automatic model_step(input stim_t s);
    exp_t e;
    bit dc, mst, hz, lu, st, tk;
    dc = m_miss ? !s.fill : (s.req && !s.hit);
    // A new multiply owes L-1 stall cycles, the first of which is this one.
    if (!dc && m_mul_left == 0 && s.ms && L > 1) m_mul_left = L - 1;
    mst = !dc && (m_mul_left > 0);
    hz  = s.ld && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    lu  = hz && !dc && !mst;
    st  = dc || mst || lu;
    tk  = (s.br || m_pend) && !st;
    e.ctrl = '0;
    if (s.rst_n) begin
      e.ctrl.takebranch     = tk;
      e.ctrl.stall          = st;
      e.ctrl.dcache_stall   = dc;
      e.ctrl.load_use_stall = lu;
    end
    e.err  = m_err;
    e.perf = PW'(m_perf);
    e.cyc  = cyc;
    sb.push_back(e);
    if (!s.rst_n) begin
      model_reset();
    end else begin
      if (mst) m_mul_left--;
      if (tk) m_pend = 0;
      else if (s.br && st) m_pend = 1;
      if (st && m_perf < (64'd1 << PW) - 1) m_perf++;
      if (m_miss) begin
        m_miss_cycles++;
        if (m_miss_cycles >= TO - 1) m_err = 1;
        if (s.fill) m_miss = 0;
      end else if (s.req && !s.hit) begin
        m_miss = 1;
        m_miss_cycles = 0;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    @(posedge clock);
    #1;
    reset           = s.rst_n;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    ex_rd           = s.rd;
    id_uses_rs1     = s.u1;
    id_uses_rs2     = s.u2;
    ex_is_load      = s.ld;
    ex_branch_taken = s.br;
    ex_mul_start    = s.ms;
    mem_dc_req      = s.req;
    mem_dc_hit      = s.hit;
    dc_fill_done    = s.fill;
    cyc++;
    model_step(s);
  endtask

  // Monitor: every cycle presents a full output set; compare it to the head.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (ctrl_signals !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl cyc=%0d got=%b want=%b (tb,st,dc,lu)", e.cyc, ctrl_signals, e.ctrl);
      end
      checks++;
      if (miss_timeout_err !== e.err) begin
        failures++;
        $display("FAIL miss_timeout_err cyc=%0d got=%b want=%b", e.cyc, miss_timeout_err, e.err);
      end
      checks++;
      if (stall_cycles !== e.perf) begin
        failures++;
        $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", e.cyc, stall_cycles, e.perf);
      end
    end
  end

  initial begin
    stim_t s;
    model_reset();
    s = idle();
    s.rst_n = 1'b0;
    reset = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0;
    ex_branch_taken = 0; ex_mul_start = 0;
    mem_dc_req = 0; mem_dc_hit = 0; dc_fill_done = 0;
    apply(s);
    apply(s);
    apply(idle());

    // Load-use on rs1, then the same with ex_rd = x0
    s = idle(); s.ld = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1;
    apply(s);
    apply(idle());
    s.rd = 5'd0; s.rs1 = 5'd0;
    apply(s);
    apply(idle());

    // Miss with refill six cycles later, load-use hazard held across it
    s = idle(); s.req = 1; s.ld = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1;
    apply(s);
    s.req = 0;
    repeat (5) apply(s);
    s.fill = 1;
    apply(s);
    apply(idle());

    // Multiply with a miss injected during the second busy cycle
    s = idle(); s.ms = 1;
    apply(s);
    apply(idle());
    s = idle(); s.req = 1;
    apply(s);
    s.req = 0;
    repeat (3) apply(s);
    s.fill = 1;
    apply(s);
    repeat (3) apply(idle());

    // Taken branch during a miss stall: resolved once the fill releases it
    s = idle(); s.req = 1; s.br = 1;
    apply(s);
    s = idle();
    repeat (3) apply(s);
    s.fill = 1;
    apply(s);
    repeat (2) apply(idle());

    // Fill pulse with no miss outstanding has no effect
    s = idle(); s.fill = 1;
    apply(s);

    // Randomised traffic
    repeat (2000) apply(rand_stim());

    // Clear any outstanding miss, then run a miss past its timeout
    s = idle(); s.rst_n = 0;
    apply(s);
    s = idle(); s.req = 1; s.br = 1;
    apply(s);
    s = idle();
    repeat (300) apply(s);
    s.rst_n = 0;
    apply(s);
    repeat (3) apply(idle());

    repeat (500) apply(rand_stim());

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
